// File: rtl/vc_pkg.sv
// rtl/vc_pkg.sv - shared constants for the per-class arbiter and demux
package vc_pkg;

  localparam int CLASS_W = 2;
  localparam int NCH     = 4;
  localparam int DATA_W  = 10;

  typedef logic [CLASS_W-1:0] class_t;

  // controller state, one-hot
  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  localparam class_t CLS0 = 2'd0;
  localparam class_t CLS1 = 2'd1;
  localparam class_t CLS2 = 2'd2;
  localparam class_t CLS3 = 2'd3;

  // pointer value after reset/flush so the first search starts at class 0
  localparam class_t RR_PTR_RST = CLS3;

endpackage

// File: rtl/vc_rr_arbiter_if.sv
// rtl/vc_rr_arbiter_if.sv - arbiter source/destination bundle; VC_ARB_STATS_EN adds grant counters
interface vc_rr_arbiter_if #(
  parameter int DATA_W = 10
);

  logic [3:0]        states;
  logic [DATA_W-1:0] fifo_data0;
  logic [DATA_W-1:0] fifo_data1;
  logic [DATA_W-1:0] fifo_data2;
  logic [DATA_W-1:0] fifo_data3;
  logic [3:0]        fifo_empty;
  logic [3:0]        dest_almost_full;
  logic [3:0]        fifo_pop;
  logic [DATA_W+1:0] data_out;
  logic              valid_out;
  logic              idle_out;
`ifdef VC_ARB_STATS_EN
  logic [15:0]       grant_cnt0;
  logic [15:0]       grant_cnt1;
  logic [15:0]       grant_cnt2;
  logic [15:0]       grant_cnt3;
`endif

  // arbiter side
  modport master (
    input  states, fifo_data0, fifo_data1, fifo_data2, fifo_data3,
    input  fifo_empty, dest_almost_full,
`ifdef VC_ARB_STATS_EN
    output grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3,
`endif
    output fifo_pop, data_out, valid_out, idle_out
  );

  // FIFO / controller / demux side
  modport slave (
    output states, fifo_data0, fifo_data1, fifo_data2, fifo_data3,
    output fifo_empty, dest_almost_full,
`ifdef VC_ARB_STATS_EN
    input  grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3,
`endif
    input  fifo_pop, data_out, valid_out, idle_out
  );

endinterface

// File: rtl/vc_rr_arbiter_rr_pick.sv
// rtl/vc_rr_arbiter_rr_pick.sv - combinational rotate-priority picker, search starts at ptr+1
module rr_pick
  import vc_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  class_t         ptr,
  output class_t         gnt_id,
  output logic           gnt_vld
);

  class_t idx;

  // walk ptr+1, ptr+2, ... (mod 4) and take the first requester; ptr itself is checked last
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = ptr + CLASS_W'(i);
      if (!gnt_vld && req[idx]) begin
        gnt_id  = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_rr_arbiter.sv
// rtl/vc_rr_arbiter.sv - 4-class round-robin merge into {class,payload} words; VC_ARB_STATS_EN adds grant counters
module vc_rr_arbiter
  import vc_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input logic              clk,
  input logic              reset_L,
  vc_rr_arbiter_if.master  bus
);

  logic [NCH-1:0]    elig;
  logic              flush;
  logic              grant_ok;
  class_t            gnt_id;
  logic              gnt_vld;
  logic              pop;
  logic [NCH-1:0]    fifo_pop_c;
  logic [DATA_W-1:0] sel_data;

  class_t            rr_ptr_q,    rr_ptr_d;
  logic              s1_vld_q,    s1_vld_d;
  class_t            s1_id_q,     s1_id_d;
  logic [DATA_W+1:0] data_out_q,  data_out_d;
  logic              valid_out_q, valid_out_d;

  assign elig     = ~bus.fifo_empty & ~bus.dest_almost_full;
  assign flush    = (bus.states == ST_RESET);
  assign grant_ok = (bus.states == ST_IDLE) || (bus.states == ST_ACTIVE);

  rr_pick u_pick (
    .req     (elig),
    .ptr     (rr_ptr_q),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  // pop is gated by reset so the strobe is quiet while reset_L is held low
  assign pop = reset_L && grant_ok && gnt_vld;

  // one-hot read strobe for the granted class
  always_comb begin
    fifo_pop_c = '0;
    if (pop) fifo_pop_c[gnt_id] = 1'b1;
  end

  // source data for the class popped last cycle
  always_comb begin
    sel_data = bus.fifo_data0;
    case (s1_id_q)
      CLS0:    sel_data = bus.fifo_data0;
      CLS1:    sel_data = bus.fifo_data1;
      CLS2:    sel_data = bus.fifo_data2;
      default: sel_data = bus.fifo_data3;
    endcase
  end

  // pointer, grant-id stage and output stage; RESET state flushes everything
  always_comb begin
    rr_ptr_d    = pop ? gnt_id : rr_ptr_q;
    s1_vld_d    = pop;
    s1_id_d     = pop ? gnt_id : s1_id_q;
    valid_out_d = s1_vld_q;
    data_out_d  = s1_vld_q ? {s1_id_q, sel_data} : data_out_q;
    if (flush) begin
      rr_ptr_d    = RR_PTR_RST;
      s1_vld_d    = 1'b0;
      s1_id_d     = '0;
      valid_out_d = 1'b0;
      data_out_d  = '0;
    end
  end

  // pipeline and pointer registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rr_ptr_q    <= RR_PTR_RST;
      s1_vld_q    <= 1'b0;
      s1_id_q     <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_vld_q    <= s1_vld_d;
      s1_id_q     <= s1_id_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign bus.fifo_pop  = fifo_pop_c;
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.idle_out  = reset_L && !flush && (elig == '0) && !s1_vld_q && !valid_out_q;

`ifdef VC_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NCH];
  logic [15:0] grant_cnt_d [NCH];

  // saturating per-class grant counters
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      grant_cnt_d[k] = grant_cnt_q[k];
      if (flush)
        grant_cnt_d[k] = '0;
      else if (fifo_pop_c[k] && (grant_cnt_q[k] != 16'hFFFF))
        grant_cnt_d[k] = grant_cnt_q[k] + 16'd1;
    end
  end

  // counter registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < NCH; k++) grant_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) grant_cnt_q[k] <= grant_cnt_d[k];
    end
  end

  assign bus.grant_cnt0 = grant_cnt_q[0];
  assign bus.grant_cnt1 = grant_cnt_q[1];
  assign bus.grant_cnt2 = grant_cnt_q[2];
  assign bus.grant_cnt3 = grant_cnt_q[3];
`endif

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// tb/tb_vc_rr_arbiter.sv - directed vector bench for vc_rr_arbiter; VC_ARB_STATS_EN enables counter checks
module tb_vc_rr_arbiter;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vc_rr_arbiter_if bus ();

  vc_rr_arbiter dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.master)
  );

  localparam logic [3:0] A = 4'b1000;
  localparam logic [3:0] I = 4'b0010;
  localparam logic [3:0] R = 4'b0001;

  typedef struct {
    logic [3:0]  st;
    logic [3:0]  emp;
    logic [3:0]  daf;
    logic [3:0]  pop;
    logic        vld;
    logic [11:0] dat;
    logic        idl;
  } vec_t;

  vec_t tv [27];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // inputs are set at posedge+1, outputs sampled at posedge+2
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.states = A;
    bus.fifo_empty = 4'b1111;
    bus.dest_almost_full = 4'b0000;
    bus.fifo_data0 = 10'h011;
    bus.fifo_data1 = 10'h122;
    bus.fifo_data2 = 10'h233;
    bus.fifo_data3 = 10'h344;

    //        st   emp      daf      pop      vld   dat      idl
    tv[0]  = '{A, 4'b0000, 4'b0000, 4'b0001, 1'b0, 12'h000, 1'b0};
    tv[1]  = '{A, 4'b0000, 4'b0000, 4'b0010, 1'b0, 12'h000, 1'b0};
    tv[2]  = '{A, 4'b0000, 4'b0000, 4'b0100, 1'b1, 12'h011, 1'b0};
    tv[3]  = '{A, 4'b0000, 4'b0000, 4'b1000, 1'b1, 12'h522, 1'b0};
    tv[4]  = '{A, 4'b0000, 4'b0000, 4'b0001, 1'b1, 12'hA33, 1'b0};
    tv[5]  = '{A, 4'b0000, 4'b0000, 4'b0010, 1'b1, 12'hF44, 1'b0};
    tv[6]  = '{A, 4'b0000, 4'b0010, 4'b0100, 1'b1, 12'h011, 1'b0};
    tv[7]  = '{A, 4'b0000, 4'b0010, 4'b1000, 1'b1, 12'h522, 1'b0};
    tv[8]  = '{A, 4'b0000, 4'b0010, 4'b0001, 1'b1, 12'hA33, 1'b0};
    tv[9]  = '{A, 4'b0000, 4'b0010, 4'b0100, 1'b1, 12'hF44, 1'b0};
    tv[10] = '{A, 4'b0000, 4'b0010, 4'b1000, 1'b1, 12'h011, 1'b0};
    tv[11] = '{A, 4'b0000, 4'b0000, 4'b0001, 1'b1, 12'hA33, 1'b0};
    tv[12] = '{A, 4'b0000, 4'b0000, 4'b0010, 1'b1, 12'hF44, 1'b0};
    tv[13] = '{I, 4'b0000, 4'b0000, 4'b0000, 1'b1, 12'h011, 1'b0};
    tv[14] = '{I, 4'b0000, 4'b0000, 4'b0000, 1'b1, 12'h522, 1'b0};
    tv[15] = '{I, 4'b0000, 4'b0000, 4'b0000, 1'b0, 12'h522, 1'b0};
    tv[16] = '{A, 4'b1111, 4'b0000, 4'b0000, 1'b0, 12'h522, 1'b1};
    tv[17] = '{A, 4'b1011, 4'b0000, 4'b0100, 1'b0, 12'h522, 1'b0};
    tv[18] = '{A, 4'b1111, 4'b0000, 4'b0000, 1'b0, 12'h522, 1'b0};
    tv[19] = '{A, 4'b1111, 4'b0000, 4'b0000, 1'b1, 12'hA33, 1'b0};
    tv[20] = '{A, 4'b1111, 4'b0000, 4'b0000, 1'b0, 12'hA33, 1'b1};
    tv[21] = '{A, 4'b0111, 4'b0000, 4'b1000, 1'b0, 12'hA33, 1'b0};
    tv[22] = '{A, 4'b0111, 4'b0000, 4'b1000, 1'b0, 12'hA33, 1'b0};
    tv[23] = '{A, 4'b1111, 4'b0000, 4'b0000, 1'b1, 12'hF44, 1'b0};
    tv[24] = '{A, 4'b1111, 4'b0000, 4'b0000, 1'b1, 12'hF44, 1'b0};
    tv[25] = '{A, 4'b1111, 4'b0000, 4'b0000, 1'b0, 12'hF44, 1'b1};
    tv[26] = '{A, 4'b0111, 4'b1000, 4'b0000, 1'b0, 12'hF44, 1'b1};

    // reset state
    step();
    step();
    chk("rst_pop", 32'(bus.fifo_pop), 32'h0);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_data", 32'(bus.data_out), 32'h0);
    chk("rst_idle", 32'(bus.idle_out), 32'h0);
    reset_L = 1'b1;
    step();

    // fairness, backpressure, INIT drain, idle, sole-class back-to-back
    for (int i = 0; i < 27; i++) begin
      bus.states = tv[i].st;
      bus.fifo_empty = tv[i].emp;
      bus.dest_almost_full = tv[i].daf;
      #1;
      chk($sformatf("v%0d_pop", i), 32'(bus.fifo_pop), 32'(tv[i].pop));
      chk($sformatf("v%0d_valid", i), 32'(bus.valid_out), 32'(tv[i].vld));
      chk($sformatf("v%0d_data", i), 32'(bus.data_out), 32'(tv[i].dat));
      chk($sformatf("v%0d_idle", i), 32'(bus.idle_out), 32'(tv[i].idl));
      step();
    end
    bus.dest_almost_full = 4'b0000;

    // payload integrity on class 3, consecutive words
    bus.fifo_empty = 4'b0111;
    #1 chk("pay_pop0", 32'(bus.fifo_pop), 32'h8);
    step();
    bus.fifo_data3 = 10'h155;
    #1 chk("pay_pop1", 32'(bus.fifo_pop), 32'h8);
    step();
    bus.fifo_empty = 4'b1111;
    bus.fifo_data3 = 10'h2AA;
    #1 chk("pay_w0_valid", 32'(bus.valid_out), 32'h1);
    chk("pay_w0_data", 32'(bus.data_out), 32'hD55);
    step();
    chk("pay_w1_valid", 32'(bus.valid_out), 32'h1);
    chk("pay_w1_data", 32'(bus.data_out), 32'hEAA);
    step();
    chk("pay_hold_valid", 32'(bus.valid_out), 32'h0);
    chk("pay_hold_data", 32'(bus.data_out), 32'hEAA);

    // asynchronous reset mid-stream
    bus.fifo_empty = 4'b0000;
    step();
    step();
    #2 reset_L = 1'b0;
    #1 chk("arst_pop", 32'(bus.fifo_pop), 32'h0);
    chk("arst_valid", 32'(bus.valid_out), 32'h0);
    chk("arst_data", 32'(bus.data_out), 32'h0);
    chk("arst_idle", 32'(bus.idle_out), 32'h0);
    step();
    reset_L = 1'b1;
    bus.fifo_empty = 4'b1011;
    #1 chk("arst_first_pop", 32'(bus.fifo_pop), 32'h4);
    step();
    bus.fifo_empty = 4'b1111;
    #1 chk("arst_s1_valid", 32'(bus.valid_out), 32'h0);
    step();
    chk("arst_out_valid", 32'(bus.valid_out), 32'h1);
    chk("arst_out_data", 32'(bus.data_out), 32'hA33);
    step();

    // synchronous flush one cycle after a pop
    bus.fifo_empty = 4'b1110;
    #1 chk("fl_pop", 32'(bus.fifo_pop), 32'h1);
    step();
    bus.states = R;
    bus.fifo_empty = 4'b1111;
    #1 chk("fl_rst_pop", 32'(bus.fifo_pop), 32'h0);
    chk("fl_rst_idle", 32'(bus.idle_out), 32'h0);
    step();
    bus.states = A;
    #1 chk("fl_valid", 32'(bus.valid_out), 32'h0);
    chk("fl_data", 32'(bus.data_out), 32'h0);
    chk("fl_idle", 32'(bus.idle_out), 32'h1);
    step();
    chk("fl_valid2", 32'(bus.valid_out), 32'h0);
    bus.fifo_empty = 4'b1101;
    #1 chk("fl_ptr_pop", 32'(bus.fifo_pop), 32'h2);
    step();
    bus.fifo_empty = 4'b1111;
    step();
    step();

`ifdef VC_ARB_STATS_EN
    // grant counters and saturation
    bus.states = R;
    step();
    bus.states = A;
    bus.fifo_empty = 4'b1110;
    for (int i = 0; i < 5; i++) step();
    bus.fifo_empty = 4'b1111;
    #1 chk("cnt0_five", 32'(bus.grant_cnt0), 32'd5);
    chk("cnt1_zero", 32'(bus.grant_cnt1), 32'd0);
    step();
    bus.fifo_empty = 4'b1101;
    for (int i = 0; i < 65535; i++) step();
    bus.fifo_empty = 4'b1111;
    #1 chk("cnt1_max", 32'(bus.grant_cnt1), 32'hFFFF);
    step();
    bus.fifo_empty = 4'b1101;
    step();
    bus.fifo_empty = 4'b1111;
    #1 chk("cnt1_sat", 32'(bus.grant_cnt1), 32'hFFFF);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
